// File: rtl/mfifo_nw_1r_if.sv
// Bus bundle for mfifo_nw_1r: multi-lane write port, single read port and
// the flow-control/status flags. Clock and reset stay outside the bundle.
interface mfifo_nw_1r_if #(
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 4,
    parameter int WR_PORTS      = 2,
    parameter int CW            = $clog2(WR_PORTS + 1)
);
    logic [WR_PORTS*DATA_WIDTH-1:0] Data_in;
    logic                           WriteEn_in;
    logic [CW-1:0]                  WriteCnt_in;
    logic                           Full_out;
    logic                           AlmostFull_out;
    logic                           Overflow_out;
    logic                           ReadEn_in;
    logic [DATA_WIDTH-1:0]          Data_out;
    logic                           Data_valid;
    logic                           Empty_out;
    logic [ADDRESS_WIDTH:0]         Count_out;

    // Producer/consumer side drives requests and observes status.
    modport master (
        output Data_in, WriteEn_in, WriteCnt_in, ReadEn_in,
        input  Full_out, AlmostFull_out, Overflow_out,
        input  Data_out, Data_valid, Empty_out, Count_out
    );

    // FIFO side.
    modport slave (
        input  Data_in, WriteEn_in, WriteCnt_in, ReadEn_in,
        output Full_out, AlmostFull_out, Overflow_out,
        output Data_out, Data_valid, Empty_out, Count_out
    );
endinterface

// File: rtl/mfifo_nw_1r.sv
// Single-clock FIFO: writes 1..WR_PORTS entries per cycle (all-or-nothing),
// pops one entry per cycle into a registered read port. Tracks exact
// occupancy, raises Full/AlmostFull and a sticky overflow on dropped writes.
module mfifo_nw_1r #(
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 4,
    parameter int WR_PORTS      = 2,
    parameter int AFULL_MARGIN  = 2,
    parameter int CW            = $clog2(WR_PORTS + 1)
) (
    input  logic          Clk,
    input  logic          Clear_n,
    mfifo_nw_1r_if.slave  bus
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int NW    = ADDRESS_WIDTH + 1;

    localparam logic [NW-1:0] DEPTH_C  = NW'(DEPTH);
    localparam logic [NW-1:0] FULL_TH  = NW'(DEPTH - WR_PORTS);
    localparam logic [NW-1:0] AFULL_TH = NW'(DEPTH - AFULL_MARGIN);
    localparam logic [CW-1:0] MAX_CNT  = CW'(WR_PORTS);

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_wptr;
    logic [ADDRESS_WIDTH-1:0] r_rptr;
    logic [NW-1:0]            r_count;
    logic                     r_overflow;
    logic [DATA_WIDTH-1:0]    r_dout;
    logic                     r_valid;

    logic [NW-1:0]            w_cnt_ext;
    logic [NW-1:0]            w_space;
    logic [NW-1:0]            w_add;
    logic                     w_req;
    logic                     w_accept;
    logic                     w_pop;

    // Space check uses the pre-edge count only, so a same-cycle pop never
    // makes room for the write and the entry being read is never overwritten.
    assign w_cnt_ext = NW'(bus.WriteCnt_in);
    assign w_space   = DEPTH_C - r_count;
    assign w_req     = bus.WriteEn_in && (bus.WriteCnt_in != '0);
    assign w_accept  = w_req && (bus.WriteCnt_in <= MAX_CNT) && (w_cnt_ext <= w_space);
    assign w_pop     = bus.ReadEn_in && (r_count != '0);
    assign w_add     = w_accept ? w_cnt_ext : '0;

    // Storage: lane i lands at wptr+i; contents are not cleared by reset.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (CW'(i) < bus.WriteCnt_in) begin
                    r_mem[r_wptr + ADDRESS_WIDTH'(i)] <= bus.Data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Pointers, occupancy, sticky overflow and the registered read port.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_count <= r_count + w_add - NW'(w_pop);
            r_valid <= w_pop;
            if (w_accept) begin
                r_wptr <= r_wptr + ADDRESS_WIDTH'(bus.WriteCnt_in);
            end
            if (w_req && !w_accept) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign bus.Count_out      = r_count;
    assign bus.Empty_out      = (r_count == '0);
    assign bus.Full_out       = (r_count > FULL_TH);
    assign bus.AlmostFull_out = (r_count >= AFULL_TH);
    assign bus.Overflow_out   = r_overflow;
    assign bus.Data_out       = r_dout;
    assign bus.Data_valid     = r_valid;
endmodule

// File: tb/tb_mfifo_nw_1r.sv
// Directed + random bench for mfifo_nw_1r with a queue model and a
// scoreboard of expected read data.
module tb_mfifo_nw_1r;
    localparam int DW    = 65;
    localparam int AW    = 4;
    localparam int WP    = 2;
    localparam int CW    = $clog2(WP + 1);
    localparam int DEPTH = 1 << AW;
    localparam int AFM   = 2;

    logic Clk = 1'b0;
    logic Clear_n;

    always #5 Clk = ~Clk;

    mfifo_nw_1r_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WR_PORTS(WP), .CW(CW)) bus ();

    mfifo_nw_1r #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WR_PORTS(WP),
        .AFULL_MARGIN(AFM), .CW(CW)
    ) dut (
        .Clk     (Clk),
        .Clear_n (Clear_n),
        .bus     (bus)
    );

    logic [DW-1:0] m_q [$];
    logic [DW-1:0] sb  [$];
    logic [DW-1:0] m_dout;
    bit            m_ovf;
    bit            m_valid;
    int            total;
    int            bad;

    function automatic logic [DW-1:0] rnd();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_dout  = '0;
    endtask

    task automatic check_outputs();
        logic [DW-1:0] e;
        int sz;
        sz = m_q.size();
        chk("count", DW'(bus.Count_out), DW'(sz));
        chk("empty", DW'(bus.Empty_out), DW'(sz == 0));
        chk("full",  DW'(bus.Full_out),  DW'(sz > DEPTH - WP));
        chk("afull", DW'(bus.AlmostFull_out), DW'(sz >= DEPTH - AFM));
        chk("ovf",   DW'(bus.Overflow_out),   DW'(m_ovf));
        chk("valid", DW'(bus.Data_valid),     DW'(m_valid));
        if (m_valid) begin
            e = sb.pop_front();
            chk("dout", bus.Data_out, e);
            m_dout = e;
        end else begin
            chk("dout_hold", bus.Data_out, m_dout);
        end
    endtask

    task automatic set_idle();
        bus.WriteEn_in  = 1'b0;
        bus.WriteCnt_in = '0;
        bus.ReadEn_in   = 1'b0;
        bus.Data_in     = '0;
    endtask

    // One clock: drive, update the model at the edge, check just after it.
    task automatic step(input bit we, input int cnt, input bit re,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int sz;
        bit acc;
        bit pop;
        bus.WriteEn_in  = we;
        bus.WriteCnt_in = CW'(cnt);
        bus.ReadEn_in   = re;
        bus.Data_in     = {d1, d0};
        @(posedge Clk);
        sz  = m_q.size();
        acc = we && cnt != 0 && cnt <= WP && cnt <= DEPTH - sz;
        pop = re && sz != 0;
        m_valid = pop;
        if (pop) sb.push_back(m_q.pop_front());
        if (acc) begin
            m_q.push_back(d0);
            if (cnt == 2) m_q.push_back(d1);
        end
        if (we && cnt != 0 && !acc) m_ovf = 1'b1;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        set_idle();
        Clear_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge Clk);
        #1;
        Clear_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();

        // Reset held with random inputs toggling
        Clear_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Data_in     = {rnd(), rnd()};
            bus.WriteEn_in  = 1'b1;
            bus.WriteCnt_in = CW'($urandom_range(0, 3));
            bus.ReadEn_in   = 1'b1;
            @(posedge Clk);
            #1;
            check_outputs();
        end
        set_idle();
        Clear_n = 1'b1;
        step(1, 2, 0, 65'h0_AAAA_AAAA_AAAA_AAAA, 65'h1_BBBB_BBBB_BBBB_BBBB);
        step(0, 0, 1, '0, '0);
        step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);

        // Ordering: counts 2,3,2,1,0 and data 1,2,3
        step(1, 2, 0, 65'h1, 65'h2);
        step(1, 1, 0, 65'h3, 65'h0);
        step(0, 0, 1, '0, '0);
        step(0, 0, 1, '0, '0);
        step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);
        step(1, 0, 1, 65'h55, 65'h66);

        // Fill to 16, then a dropped write sets sticky overflow
        for (int i = 0; i < 7; i++) step(1, 2, 0, rnd(), rnd());
        step(1, 1, 0, rnd(), rnd());
        step(1, 1, 0, rnd(), rnd());
        step(1, 2, 0, rnd(), rnd());
        step(0, 0, 0, '0, '0);

        // Same-cycle write/pop at 15 (dropped) and 14 (accepted)
        step(0, 0, 1, '0, '0);
        step(1, 2, 1, rnd(), rnd());
        step(1, 2, 1, rnd(), rnd());
        for (int i = 0; i < 16; i++) step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);

        // Wrap-around: park both pointers at 15, then write across the edge
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 2, 0, rnd(), rnd());
        step(1, 1, 0, rnd(), rnd());
        for (int i = 0; i < 15; i++) step(0, 0, 1, '0, '0);
        step(1, 2, 0, 65'h1_0000_0000_0000_00F0, 65'h0_FFFF_0000_FFFF_0000);
        step(0, 0, 1, '0, '0);
        step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            int c;
            c = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            step(bit'($urandom_range(0, 1)), c, bit'($urandom_range(0, 9) < 6), rnd(), rnd());
        end
        for (int i = 0; i < 18; i++) step(0, 0, 1, '0, '0);

        // Asynchronous reset between edges with count=9 and a pop in flight
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 2, 0, rnd(), rnd());
        step(0, 0, 1, '0, '0);
        set_idle();
        #2;
        Clear_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge Clk);
        #1;
        Clear_n = 1'b1;
        step(1, 2, 0, 65'h0_1234, 65'h0_5678);
        step(0, 0, 1, '0, '0);
        step(0, 0, 1, '0, '0);
        step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mfifo_nw_1r.md
# mfifo_nw_1r

Single-clock FIFO that accepts a variable number of entries (1..WR_PORTS) per cycle on a multi-lane write port and drains one entry per cycle on a registered read port. It is the parametrised successor to the team's 2-write/1-read FIFO, which has a fixed write width and no full protection. It adds true occupancy tracking, full/almost-full flow control, overflow detection and generalised lane count. It sits between multi-result producer stages and single-consumer pipeline stages.

## Interface
- DATA_WIDTH, 65, bits per entry
- ADDRESS_WIDTH, 4, log2 of depth; DEPTH = 1<<ADDRESS_WIDTH
- WR_PORTS, 2, write lanes per cycle; legal range 1 <= WR_PORTS <= DEPTH/2
- AFULL_MARGIN, 2, AlmostFull threshold distance from DEPTH
- CW, $clog2(WR_PORTS+1), derived width of WriteCnt_in
- Clk  in  1  single clock, rising edge
- Clear_n  in  1  reset, asynchronous and active-low
- Data_in  in  WR_PORTS*DATA_WIDTH  lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- WriteEn_in  in  1  write request
- WriteCnt_in  in  CW  number of lanes to write (0..WR_PORTS); lanes 0..cnt-1 are used
- Full_out  out  1  FIFO cannot accept a maximal write this cycle
- AlmostFull_out  out  1  Count_out >= DEPTH-AFULL_MARGIN
- Overflow_out  out  1  sticky: a write was dropped
- ReadEn_in  in  1  pop request
- Data_out  out  DATA_WIDTH  registered read data
- Data_valid  out  1  Data_out holds a freshly popped entry this cycle
- Empty_out  out  1  Count_out == 0
- Count_out  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH

## Operation
- State: binary wptr and rptr (ADDRESS_WIDTH bits, wrap modulo DEPTH), count (ADDRESS_WIDTH+1 bits), storage array of DEPTH entries.
- Write accept: accepted iff WriteEn_in && WriteCnt_in != 0 && WriteCnt_in <= DEPTH - count, where count is the pre-edge value.
- An accepted write stores lane i at mem[(wptr+i) mod DEPTH] for i < WriteCnt_in.
  - wptr advances by WriteCnt_in, modulo DEPTH.
- Writes are all-or-nothing.
  - A request with WriteEn_in=1, WriteCnt_in != 0 and insufficient space writes nothing, leaves wptr unchanged, and sets Overflow_out.
  - Overflow_out clears only on reset.
- WriteCnt_in > WR_PORTS is illegal. It is treated as dropped and sets Overflow_out.
- WriteEn_in=1 with WriteCnt_in=0 is a no-op.
- Pop: pop = ReadEn_in && !Empty_out.
  - On pop: Data_out <= mem[rptr], rptr advances by 1, and Data_valid=1 in the next cycle.
  - With no pop: Data_valid=0 and Data_out holds its value.
- ReadEn_in while empty is ignored: no pointer movement, no flag.
- Count update: count <= count + (accepted ? WriteCnt_in : 0) - (pop ? 1 : 0).
- Full_out = count > DEPTH - WR_PORTS.
- Empty_out, Full_out and AlmostFull_out are combinational decodes of the registered count.
- Simultaneous write and pop:
  - Both occur.
  - Space freed by the same-cycle pop is not usable by the write; the space check uses pre-edge count.
  - A write never overwrites the entry being read.

## Timing
- Reset (Clear_n low, immediate, independent of Clk): wptr=rptr=0, count=0, Data_out=0, Data_valid=0, Overflow_out=0.
  - Resulting outputs: Empty_out=1, Full_out=0, AlmostFull_out=0, Count_out=0.
  - Reset mid-operation discards all contents. Storage need not be cleared.
- Write-to-visible latency: data written at edge t gives Empty_out=0 and updated Count_out after edge t.
  - The earliest pop is at edge t+1.
  - Data_out and Data_valid appear after edge t+1.
  - Total: two edges from write to Data_out.
- Pop-to-data latency: 1 cycle, with Data_valid high exactly one cycle per pop.
- Sustained throughput: 1 pop per cycle, up to WR_PORTS writes per cycle.
- Flags update in the same cycle as Count_out, with no extra register stage.

## Test plan
DEPTH=16, WR_PORTS=2, AFULL_MARGIN=2 unless stated.

- Reset check: hold Clear_n=0 with random inputs -> Empty_out=1, Full_out=0, Count_out=0, Data_valid=0, Data_out=0. Release, then write cnt=2 {A,B} -> Count_out=2 next cycle.
- Ordering: write cnt=2 {0x1,0x2}, then cnt=1 {0x3}, then 3 pops -> Data_out 0x1,0x2,0x3 on consecutive cycles, Data_valid 1,1,1 then 0. Count_out goes 2,3,2,1,0.
- Fill and overflow:
  - 7 writes of cnt=2 -> Count_out=14, AlmostFull_out=1, Full_out=0.
  - cnt=1 -> 15, Full_out=1.
  - cnt=1 -> 16 accepted.
  - cnt=2 -> dropped, Count_out=16, Overflow_out=1, which stays 1 until reset.
- Same-cycle read/write at count=15: WriteCnt_in=2 and ReadEn_in=1 -> write dropped, pop proceeds, Count_out=14, Overflow_out=1. Repeat at count=14 -> write accepted, Count_out=15.
- Wrap-around:
  - Preload rptr=wptr=15 by writing and popping 15 entries.
  - Write cnt=2 {X,Y} -> stored at indices 15 and 0.
  - Two pops -> X then Y.
  - Random 10k-cycle run against a queue model: no loss, no reorder, Count_out exact.
- Async reset mid-stream: assert Clear_n between edges while Count_out=9 and Data_valid=1 -> all outputs reach reset values before the next edge. Subsequent traffic starts fresh with no stale data.
